cpu_core: RTL and testbench
===========================

CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 16, instruction word width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, register/data width.
REQ-003 SHALL have parameter INSTR_ADDR_WIDTH, default 10, instruction address width.
REQ-004 SHALL have parameter DATA_ADDR_WIDTH, default 10, data address width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 instr_mem_addr  out  INSTR_ADDR_WIDTH  fetch address; memory returns data_0=mem[addr], data_1=mem[addr+1] one cycle later.
REQ-009 instr_mem_data_0 / instr_mem_data_1  in  INSTRUCTION_WIDTH  instruction word / following immediate word.
REQ-010 data_mem_addr  out  DATA_ADDR_WIDTH  data address; synchronous read, read_data valid next cycle.
REQ-011 data_mem_read_data  in  DATA_WIDTH; data_mem_write_enable  out  1; data_mem_write_data  out  DATA_WIDTH.
REQ-012 accel_id  out  4  accelerator select; accel_can_read / accel_can_write  in  1  readiness.
REQ-013 accel_read_enable  out  1; accel_read_data  in  DATA_WIDTH; accel_write_enable  out  1; accel_write_data  out  DATA_WIDTH.

Function
REQ-014 SHALL hold internal pc (INSTR_ADDR_WIDTH, wraps modulo 2^W), 32-bit executed counter, and register file regs[1..15]; r0 reads 0, writes to r0 discarded.
REQ-015 Encoding: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2; imm = data_1.
REQ-016 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by rs2[3:0], 6 SHR logical by rs2[3:0], all rd=rs1 op rs2, 16-bit wrap, pc+=1.
REQ-017 7 LI rd=imm, pc+=2; 8 LOAD rd=mem[rs1[9:0]], pc+=1; 9 STORE mem[rs1[9:0]]=rs2, pc+=1.
REQ-018 A JMP pc=imm[9:0]; B BEQZ pc=(rs1==0)?imm:pc+2; C BLT signed rs1<rs2 ? imm : pc+2.
REQ-019 D ACCRD rd=accel_read_data, accel_id=rs2 field; E ACCWR accel_write_data=rs1, accel_id=rs2 field; both pc+=1.
REQ-020 F MUL rd=low 16 bits of rs1*rs2 (see Configuration).
REQ-021 FSM states FETCH, EXECUTE, MEM; FETCH drives instr_mem_addr=pc, goes to EXECUTE.
REQ-022 EXECUTE: decode data_0/data_1, write rd and update pc at cycle end, executed+=1, return to FETCH; 2 cycles per instruction.
REQ-023 LOAD: EXECUTE drives data_mem_addr, goes to MEM; MEM writes rd, updates pc, executed+=1; 3 cycles total.
REQ-024 STORE: data_mem_write_enable=1 for exactly the EXECUTE cycle with addr/data valid.
REQ-025 ACCRD/ACCWR: stay in EXECUTE while accel_can_read/accel_can_write low; enable pulses one cycle when ready; completion same cycle.
REQ-026 write_enable outputs SHALL be 0 outside their issuing cycle; unused outputs hold 0.

Reset
REQ-027 On rst low: state FETCH, pc=0, executed=0, regs=0, all enables 0, addresses 0, immediately and asynchronously.
REQ-028 Reset mid-instruction SHALL abort with no register, memory or accelerator write completing.
REQ-029 First fetch from address 0 on first rising edge after rst deasserts.

Configuration
REQ-030 Macro CPU_MUL_EN defined: opcode F performs MUL; undefined: opcode F is NOP (pc+=1, executed+=1, no register write, no multiplier synthesized).

Verification
REQ-031 Reset, program all-zero (ADD r0) -> pc increments 1 every 2 cycles, executed counts, regs stay 0.
REQ-032 LI r1,5; LI r2,7; ADD r3,r1,r2 -> r3=12, pc=5, executed=3 after 6 cycles.
REQ-033 LI r1,100; LI r2,0xBEEF; STORE [r1]=r2; LOAD r4,[r1] -> r4=0xBEEF, LOAD takes 3 cycles.
REQ-034 LI r1,0; BEEQZ r1,10 -> pc=10; BLT with r1=-1,r2=1 -> taken; LI to r0 -> r0 stays 0.
REQ-035 ACCRD r5, id 3 with accel_can_read=0 for 4 cycles then 1, read_data=42 -> r5=42, one read_enable pulse, accel_id=3.
REQ-036 MUL r3=300*300 -> r3=0x5F90 with CPU_MUL_EN; r3 unchanged without.

Source files
------------

// File: rtl/cpu_core.sv
`default_nettype none
// =============================================================================
// cpu_core : multi-cycle 16-opcode CPU (FETCH / EXECUTE / MEM) with
//            accelerator port. Define CPU_MUL_EN to make opcode F a MUL.
// Revision : 1.0
// =============================================================================
module cpu_core #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int DATA_WIDTH        = 16,
    parameter int INSTR_ADDR_WIDTH  = 10,
    parameter int DATA_ADDR_WIDTH   = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [INSTR_ADDR_WIDTH-1:0]  instr_mem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_mem_data_0,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_mem_data_1,
    output logic [DATA_ADDR_WIDTH-1:0]   data_mem_addr,
    input  logic [DATA_WIDTH-1:0]        data_mem_read_data,
    output logic                         data_mem_write_enable,
    output logic [DATA_WIDTH-1:0]        data_mem_write_data,
    output logic [3:0]                   accel_id,
    input  logic                         accel_can_read,
    input  logic                         accel_can_write,
    output logic                         accel_read_enable,
    input  logic [DATA_WIDTH-1:0]        accel_read_data,
    output logic                         accel_write_enable,
    output logic [DATA_WIDTH-1:0]        accel_write_data
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_MEM     = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [INSTR_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]                 executed_q, executed_d;
    logic [3:0]                  load_rd_q, load_rd_d;
    logic [DATA_WIDTH-1:0]       regs_q [1:15];
    logic [DATA_WIDTH-1:0]       regs_d [1:15];

    logic [3:0]                  opcode, rd, rs1_idx, rs2_idx;
    logic [DATA_WIDTH-1:0]       rs1_val, rs2_val, imm;
    logic [INSTR_ADDR_WIDTH-1:0] pc_inc1, pc_inc2, pc_imm;
    logic                        wr_en, retire;
    logic [3:0]                  wr_idx;
    logic [DATA_WIDTH-1:0]       wr_val;

    assign opcode  = instr_mem_data_0[15:12];
    assign rd      = instr_mem_data_0[11:8];
    assign rs1_idx = instr_mem_data_0[7:4];
    assign rs2_idx = instr_mem_data_0[3:0];
    assign imm     = DATA_WIDTH'(instr_mem_data_1);
    assign rs1_val = (rs1_idx == 4'd0) ? '0 : regs_q[rs1_idx];
    assign rs2_val = (rs2_idx == 4'd0) ? '0 : regs_q[rs2_idx];
    assign pc_inc1 = pc_q + INSTR_ADDR_WIDTH'(1);
    assign pc_inc2 = pc_q + INSTR_ADDR_WIDTH'(2);
    assign pc_imm  = imm[INSTR_ADDR_WIDTH-1:0];

    // The fetch address is the pc flop itself, so it is registered and valid in FETCH.
    assign instr_mem_addr = pc_q;

    always_comb begin
        state_d               = state_q;
        pc_d                  = pc_q;
        executed_d            = executed_q;
        load_rd_d             = load_rd_q;
        wr_en                 = 1'b0;
        wr_idx                = rd;
        wr_val                = '0;
        retire                = 1'b0;
        data_mem_addr         = '0;
        data_mem_write_enable = 1'b0;
        data_mem_write_data   = '0;
        accel_id              = 4'd0;
        accel_read_enable     = 1'b0;
        accel_write_enable    = 1'b0;
        accel_write_data      = '0;

        case (state_q)
            S_FETCH: state_d = S_EXECUTE;
            S_EXECUTE: begin
                pc_d   = pc_inc1;
                retire = 1'b1;
                case (opcode)
                    4'h0: begin wr_en = 1'b1; wr_val = rs1_val + rs2_val; end
                    4'h1: begin wr_en = 1'b1; wr_val = rs1_val - rs2_val; end
                    4'h2: begin wr_en = 1'b1; wr_val = rs1_val & rs2_val; end
                    4'h3: begin wr_en = 1'b1; wr_val = rs1_val | rs2_val; end
                    4'h4: begin wr_en = 1'b1; wr_val = rs1_val ^ rs2_val; end
                    4'h5: begin wr_en = 1'b1; wr_val = rs1_val << rs2_val[3:0]; end
                    4'h6: begin wr_en = 1'b1; wr_val = rs1_val >> rs2_val[3:0]; end
                    4'h7: begin wr_en = 1'b1; wr_val = imm; pc_d = pc_inc2; end
                    4'h8: begin
                        // Read data arrives next cycle; rd is remembered for the MEM write.
                        data_mem_addr = rs1_val[DATA_ADDR_WIDTH-1:0];
                        load_rd_d     = rd;
                        pc_d          = pc_q;
                        retire        = 1'b0;
                        state_d       = S_MEM;
                    end
                    4'h9: begin
                        data_mem_addr         = rs1_val[DATA_ADDR_WIDTH-1:0];
                        data_mem_write_enable = 1'b1;
                        data_mem_write_data   = rs2_val;
                    end
                    4'hA: pc_d = pc_imm;
                    4'hB: pc_d = (rs1_val == '0) ? pc_imm : pc_inc2;
                    4'hC: pc_d = ($signed(rs1_val) < $signed(rs2_val)) ? pc_imm : pc_inc2;
                    4'hD: begin
                        accel_id          = rs2_idx;
                        accel_read_enable = accel_can_read;
                        wr_en             = accel_can_read;
                        wr_val            = accel_read_data;
                        retire            = accel_can_read;
                        if (!accel_can_read) pc_d = pc_q;
                    end
                    4'hE: begin
                        accel_id           = rs2_idx;
                        accel_write_data   = rs1_val;
                        accel_write_enable = accel_can_write;
                        retire             = accel_can_write;
                        if (!accel_can_write) pc_d = pc_q;
                    end
                    4'hF: begin
`ifdef CPU_MUL_EN
                        wr_en  = 1'b1;
                        wr_val = rs1_val * rs2_val;
`endif
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                wr_en  = 1'b1;
                wr_idx = load_rd_q;
                wr_val = data_mem_read_data;
                pc_d   = pc_inc1;
                retire = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        if (retire) begin
            executed_d = executed_q + 32'd1;
            state_d    = S_FETCH;
        end

        for (int i = 1; i <= 15; i++) begin
            regs_d[i] = (wr_en && (wr_idx == 4'(i))) ? wr_val : regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            executed_q <= '0;
            load_rd_q  <= '0;
            for (int i = 1; i <= 15; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            executed_q <= executed_d;
            load_rd_q  <= load_rd_d;
            for (int i = 1; i <= 15; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// =============================================================================
// tb_cpu_core : random programs checked against an instruction-level model.
// Revision    : 1.0
// =============================================================================
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  instr_mem_addr;
    logic [15:0] instr_mem_data_0 = '0;
    logic [15:0] instr_mem_data_1 = '0;
    logic [9:0]  data_mem_addr;
    logic [15:0] data_mem_read_data = '0;
    logic        data_mem_write_enable;
    logic [15:0] data_mem_write_data;
    logic [3:0]  accel_id;
    logic        accel_can_read = 1'b0;
    logic        accel_can_write = 1'b0;
    logic        accel_read_enable;
    logic [15:0] accel_read_data = '0;
    logic        accel_write_enable;
    logic [15:0] accel_write_data;

    cpu_core dut (
        .clk                   (clk),
        .rst                   (rst),
        .instr_mem_addr        (instr_mem_addr),
        .instr_mem_data_0      (instr_mem_data_0),
        .instr_mem_data_1      (instr_mem_data_1),
        .data_mem_addr         (data_mem_addr),
        .data_mem_read_data    (data_mem_read_data),
        .data_mem_write_enable (data_mem_write_enable),
        .data_mem_write_data   (data_mem_write_data),
        .accel_id              (accel_id),
        .accel_can_read        (accel_can_read),
        .accel_can_write       (accel_can_write),
        .accel_read_enable     (accel_read_enable),
        .accel_read_data       (accel_read_data),
        .accel_write_enable    (accel_write_enable),
        .accel_write_data      (accel_write_data)
    );

    always #5 clk = ~clk;

    logic [15:0] imem   [0:1023];
    logic [15:0] dmem   [0:1023];
    logic [15:0] m_dmem [0:1023];
    logic [15:0] m_regs [0:15];
    logic [9:0]  m_pc;
    logic [31:0] m_exec;
    logic [9:0]  fetch_next;
    int          n_vec = 0;
    int          n_bad = 0;

    assign fetch_next = instr_mem_addr + 10'd1;

    // Memory environment seen by the DUT.
    always @(posedge clk) begin
        instr_mem_data_0 <= imem[instr_mem_addr];
        instr_mem_data_1 <= imem[fetch_next];
        if (data_mem_write_enable) dmem[data_mem_addr] <= data_mem_write_data;
        data_mem_read_data <= dmem[data_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (pc %0d)", tag, got, exp, m_pc);
        end
    endtask

    task automatic model_reset();
        m_pc   = '0;
        m_exec = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
    endtask

    // Runs one instruction; entered and left at the negedge of a FETCH cycle.
    task automatic run_one();
        logic [15:0] w, imm, a, b, res, ar;
        logic [3:0]  op, rd, s1, s2;
        logic [9:0]  next_pc;
        logic        has_wr;
        int          waits;
        w   = imem[m_pc];
        imm = imem[m_pc + 10'd1];
        op = w[15:12]; rd = w[11:8]; s1 = w[7:4]; s2 = w[3:0];
        a = m_regs[s1]; b = m_regs[s2];
        next_pc = m_pc + 10'd1;
        has_wr  = 1'b1;
        res     = '0;

        check("fetch_pc", 32'(instr_mem_addr), 32'(m_pc));
        check("executed", dut.executed_q, m_exec);
        @(negedge clk);
        if (op != 4'h9) check("no_store_we", 32'(data_mem_write_enable), 0);

        case (op)
            4'h0: res = a + b;
            4'h1: res = a - b;
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = a << b[3:0];
            4'h6: res = a >> b[3:0];
            4'h7: begin res = imm; next_pc = m_pc + 10'd2; end
            4'h8: begin
                check("ld_addr", 32'(data_mem_addr), 32'(a[9:0]));
                @(negedge clk);
                check("ld_mem_we", 32'(data_mem_write_enable), 0);
                res = m_dmem[a[9:0]];
            end
            4'h9: begin
                check("st_we", 32'(data_mem_write_enable), 1);
                check("st_addr", 32'(data_mem_addr), 32'(a[9:0]));
                check("st_data", 32'(data_mem_write_data), 32'(b));
                m_dmem[a[9:0]] = b;
                has_wr = 1'b0;
            end
            4'hA: begin next_pc = imm[9:0]; has_wr = 1'b0; end
            4'hB: begin next_pc = (a == 16'd0) ? imm[9:0] : m_pc + 10'd2; has_wr = 1'b0; end
            4'hC: begin
                next_pc = ($signed(a) < $signed(b)) ? imm[9:0] : m_pc + 10'd2;
                has_wr  = 1'b0;
            end
            4'hD: begin
                waits = $urandom_range(0, 4);
                repeat (waits) begin
                    accel_can_read = 1'b0;
                    #1 check("accrd_wait_en", 32'(accel_read_enable), 0);
                    @(negedge clk);
                end
                ar = 16'($urandom);
                accel_can_read  = 1'b1;
                accel_read_data = ar;
                #1;
                check("accrd_en", 32'(accel_read_enable), 1);
                check("accrd_id", 32'(accel_id), 32'(s2));
                res = ar;
            end
            4'hE: begin
                waits = $urandom_range(0, 4);
                repeat (waits) begin
                    accel_can_write = 1'b0;
                    #1 check("accwr_wait_en", 32'(accel_write_enable), 0);
                    @(negedge clk);
                end
                accel_can_write = 1'b1;
                #1;
                check("accwr_en", 32'(accel_write_enable), 1);
                check("accwr_id", 32'(accel_id), 32'(s2));
                check("accwr_data", 32'(accel_write_data), 32'(a));
                has_wr = 1'b0;
            end
            4'hF: begin
`ifdef CPU_MUL_EN
                res = a * b;
`else
                has_wr = 1'b0;
`endif
            end
            default: ;
        endcase

        @(negedge clk);
        accel_can_read  = 1'b0;
        accel_can_write = 1'b0;
        if (has_wr && rd != 4'd0) m_regs[rd] = res;
        m_pc   = next_pc;
        m_exec = m_exec + 32'd1;
    endtask

    initial begin
        int bad_words;
        for (int i = 0; i < 1024; i++) begin
            imem[i]   = 16'($urandom);
            dmem[i]   = 16'($urandom);
            m_dmem[i] = dmem[i];
        end
        // Directed prefix: LI/ADD, LI to r0, BLT -1<1, MUL 300*300, ACCRD/ACCWR id 3.
        imem[0]  = 16'h7100; imem[1]  = 16'd5;
        imem[2]  = 16'h7200; imem[3]  = 16'd7;
        imem[4]  = 16'h0312;
        imem[5]  = 16'h9013;
        imem[6]  = 16'h7000; imem[7]  = 16'd9;
        imem[8]  = 16'h9010;
        imem[9]  = 16'h7100; imem[10] = 16'hFFFF;
        imem[11] = 16'h7200; imem[12] = 16'd1;
        imem[13] = 16'hC012; imem[14] = 16'd20;
        imem[20] = 16'h7100; imem[21] = 16'd300;
        imem[22] = 16'hF311;
        imem[23] = 16'h9023;
        imem[24] = 16'hD503;
        imem[25] = 16'hE053;
        imem[26] = 16'hA000; imem[27] = 16'd40;
        imem[40] = 16'h7100; imem[41] = 16'd0;
        imem[42] = 16'hB010; imem[43] = 16'd50;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pc", 32'(instr_mem_addr), 0);
        check("rst_we", 32'(data_mem_write_enable), 0);
        check("rst_acc_en", 32'({accel_read_enable, accel_write_enable}), 0);
        check("rst_exec", dut.executed_q, 0);
        rst = 1'b1;

        repeat (300) run_one();

        // Reset asserted in the EXECUTE cycle of a STORE must abort the write.
        imem[m_pc] = 16'h9012;
        @(negedge clk);
        #1 check("abort_we_pre", 32'(data_mem_write_enable), 1);
        rst = 1'b0;
        #1;
        check("abort_we", 32'(data_mem_write_enable), 0);
        check("abort_pc", 32'(instr_mem_addr), 0);
        check("abort_exec", dut.executed_q, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        repeat (200) run_one();

        bad_words = 0;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== m_dmem[i]) bad_words++;
        check("dmem_final", 32'(bad_words), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
